// File: rtl/seq_acc_requant.sv
// Tile accumulator with round-half-up requantization and saturation.
// Optional zero-clamp of negative results: define SEQ_ACC_RELU_EN.
module seq_acc_requant #(
    parameter int IN_WIDTH  = 32,
    parameter int CNT_WIDTH = 8,
    parameter int ACC_WIDTH = 40,
    parameter int OUT_WIDTH = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic signed [IN_WIDTH-1:0]  d_i,
    input  logic                        valid_in,
    output logic                        ready_in,
    input  logic [CNT_WIDTH-1:0]        acc_len_i,
    input  logic [4:0]                  shift_i,
    output logic signed [OUT_WIDTH-1:0] q_o,
    output logic                        sat_o,
    output logic                        valid_out,
    input  logic                        ready_out,
    output logic                        busy_o
);

    if (ACC_WIDTH < IN_WIDTH + CNT_WIDTH) begin : g_width_chk
        $error("ACC_WIDTH must be at least IN_WIDTH+CNT_WIDTH");
    end

    typedef enum logic [1:0] {IDLE, ACCUM, ROUND, OUT} state_t;

    localparam logic signed [ACC_WIDTH:0] Q_MAX =
        {{(ACC_WIDTH + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] Q_MIN =
        {{(ACC_WIDTH + 2 - OUT_WIDTH){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    state_t                      state;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] d_ext;
    logic [CNT_WIDTH-1:0]        cnt;
    logic [CNT_WIDTH-1:0]        len;
    logic [4:0]                  shift;
    logic signed [ACC_WIDTH:0]   acc_x;
    logic signed [ACC_WIDTH:0]   half;
    logic signed [ACC_WIDTH:0]   sum;
    logic signed [ACC_WIDTH:0]   r;
    logic signed [ACC_WIDTH:0]   r_c;
    logic signed [OUT_WIDTH-1:0] q_c;
    logic                        sat_c;

    assign ready_in = (state == IDLE) || (state == ACCUM);
    assign busy_o   = (state != IDLE);
    assign d_ext    = ACC_WIDTH'(d_i);

    // half is 2^(shift-1) for shift>0 and 0 for shift==0, so no branch is needed
    always_comb begin
        acc_x = (ACC_WIDTH + 1)'(acc);
        half  = ((ACC_WIDTH + 1)'(1) << shift) >> 1;
        sum   = acc_x + half;
        r     = sum >>> shift;
`ifdef SEQ_ACC_RELU_EN
        r_c   = (r < 0) ? '0 : r;
`else
        r_c   = r;
`endif
        q_c   = r_c[OUT_WIDTH-1:0];
        sat_c = 1'b0;
        if (r_c > Q_MAX) begin
            q_c   = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
            sat_c = 1'b1;
        end else if (r_c < Q_MIN) begin
            q_c   = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
            sat_c = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            len       <= '0;
            shift     <= '0;
            q_o       <= '0;
            sat_o     <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (valid_in) begin
                        acc   <= d_ext;
                        len   <= (acc_len_i == '0) ? CNT_WIDTH'(1) : acc_len_i;
                        shift <= shift_i;
                        cnt   <= CNT_WIDTH'(1);
                        state <= (acc_len_i <= CNT_WIDTH'(1)) ? ROUND : ACCUM;
                    end
                end
                ACCUM: begin
                    if (valid_in) begin
                        acc <= acc + d_ext;
                        cnt <= cnt + CNT_WIDTH'(1);
                        if ((cnt + CNT_WIDTH'(1)) == len) state <= ROUND;
                    end
                end
                ROUND: begin
                    q_o       <= q_c;
                    sat_o     <= sat_c;
                    valid_out <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (ready_out) begin
                        valid_out <= 1'b0;
                        acc       <= '0;
                        cnt       <= '0;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_acc_requant.sv
// Directed bench for seq_acc_requant with a queue of expected tile results.
module tb_seq_acc_requant;

    logic               clk_i = 1'b0;
    logic               rst_ni = 1'b0;
    logic signed [31:0] d_i = '0;
    logic               valid_in = 1'b0;
    logic               ready_in;
    logic [7:0]         acc_len_i = '0;
    logic [4:0]         shift_i = '0;
    logic signed [15:0] q_o;
    logic               sat_o;
    logic               valid_out;
    logic               ready_out = 1'b0;
    logic               busy_o;

    typedef struct {
        logic signed [15:0] q;
        logic               sat;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    seq_acc_requant dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .d_i       (d_i),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .acc_len_i (acc_len_i),
        .shift_i   (shift_i),
        .q_o       (q_o),
        .sat_o     (sat_o),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .busy_o    (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic exp_t model(input longint s, input int sh);
        longint r;
        exp_t   e;
        if (sh == 0) r = s;
        else r = (s + (longint'(1) <<< (sh - 1))) >>> sh;
`ifdef SEQ_ACC_RELU_EN
        if (r < 0) r = 0;
`endif
        e.sat = 1'b0;
        if (r > 32767) begin
            r = 32767;
            e.sat = 1'b1;
        end else if (r < -32768) begin
            r = -32768;
            e.sat = 1'b1;
        end
        e.q = r[15:0];
        return e;
    endfunction

    task automatic beat(input int d);
        int w = 0;
        d_i = d;
        valid_in = 1'b1;
        while (!ready_in && w < 50) begin
            tick();
            w++;
        end
        check("in_ready", ready_in, 1);
        tick();
        valid_in = 1'b0;
    endtask

    task automatic tile(input int alen, input int sh, input int ds[4],
                        input int n, input int gap);
        longint s = 0;
        for (int i = 0; i < n; i++) s += ds[i];
        sb.push_back(model(s, sh));
        acc_len_i = alen[7:0];
        shift_i = sh[4:0];
        for (int i = 0; i < n; i++) begin
            if (i > 0) repeat (gap) tick();
            beat(ds[i]);
            // scramble config: only the first-beat values may matter
            acc_len_i = 8'd3;
            shift_i = 5'd7;
        end
    endtask

    task automatic collect(input string tag, input int hold);
        int w = 0;
        exp_t e;
        logic signed [15:0] q0;
        while (!valid_out && w < 50) begin
            tick();
            w++;
        end
        check({tag, "_valid"}, valid_out, 1);
        e = sb.pop_front();
        check({tag, "_q"}, q_o, e.q);
        check({tag, "_sat"}, sat_o, e.sat);
        q0 = q_o;
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold_q"}, q_o, q0);
            check({tag, "_hold_v"}, valid_out, 1);
            check({tag, "_hold_rdy"}, ready_in, 0);
        end
        ready_out = 1'b1;
        tick();
        ready_out = 1'b0;
        check({tag, "_drop_v"}, valid_out, 0);
        check({tag, "_idle"}, busy_o, 0);
        check({tag, "_rdy_back"}, ready_in, 1);
    endtask

    initial begin
        #2;
        check("rst_valid", valid_out, 0);
        check("rst_q", q_o, 0);
        check("rst_sat", sat_o, 0);
        check("rst_busy", busy_o, 0);
        tick();
        rst_ni = 1'b1;
        tick();
        check("idle_ready", ready_in, 1);

        tile(1, 0, '{1234, 0, 0, 0}, 1, 0);
        check("lat_round_v", valid_out, 0);
        check("lat_round_rdy", ready_in, 0);
        check("lat_busy", busy_o, 1);
        tick();
        check("lat_out_v", valid_out, 1);
        collect("t1234", 0);

        tile(4, 2, '{100, -50, 7, 3}, 4, 2);
        collect("t4beat", 0);

        tile(1, 2, '{-6, 0, 0, 0}, 1, 0);
        collect("rnd_m6", 0);
        tile(1, 2, '{-7, 0, 0, 0}, 1, 0);
        collect("rnd_m7", 0);
        tile(1, 2, '{6, 0, 0, 0}, 1, 0);
        collect("rnd_p6", 0);

        tile(2, 0, '{40000, 40000, 0, 0}, 2, 0);
        collect("sat_pos", 0);
        tile(2, 0, '{-40000, -40000, 0, 0}, 2, 1);
        collect("sat_neg", 5);

        tile(0, 0, '{5, 0, 0, 0}, 1, 0);
        collect("len0", 0);

        acc_len_i = 8'd4;
        shift_i = 5'd0;
        beat(1000);
        beat(2000);
        check("mid_busy", busy_o, 1);
        rst_ni = 1'b0;
        #1;
        check("mrst_valid", valid_out, 0);
        check("mrst_q", q_o, 0);
        check("mrst_sat", sat_o, 0);
        check("mrst_busy", busy_o, 0);
        tick();
        rst_ni = 1'b1;
        tick();
        tile(1, 0, '{9, 0, 0, 0}, 1, 0);
        collect("after_rst", 0);

        tile(1, 0, '{-500, 0, 0, 0}, 1, 0);
        collect("relu", 0);

        tile(3, 4, '{-1000, 77, 31, 0}, 3, 0);
        collect("mix", 2);

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
